// File: rtl/fir_pkg.sv
// Shared sizing helpers for the pipelined FIR: accumulator width, latency and
// saturation limits.
package fir_pkg;

  function automatic int unsigned acc_w(int unsigned taps, int unsigned data_w,
                                        int unsigned coef_w);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Delay line, product, adder tree levels, output register.
  function automatic int unsigned latency(int unsigned taps);
    return 3 + $clog2(taps);
  endfunction

  function automatic longint sat_max(int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree: log2(N) levels, each one bit wider than the last.
// All levels live in one flat bus so each level can address the previous one by offset.
module fir_adder_tree #(
  parameter int unsigned N    = 32,
  parameter int unsigned IN_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic signed [IN_W-1:0]            in_data [N],
  output logic signed [IN_W+$clog2(N)-1:0]  sum
);

  function automatic int unsigned lvl_off(int unsigned l);
    int unsigned o = 0;
    for (int unsigned m = 0; m < l; m++) o += (N >> m) * (IN_W + m);
    return o;
  endfunction

  localparam int unsigned LVLS  = $clog2(N);
  localparam int unsigned OUT_W = IN_W + LVLS;
  localparam int unsigned TOT_W = lvl_off(LVLS + 1);

  logic [TOT_W-1:0] node;

  for (genvar j = 0; j < N; j++) begin : g_in
    assign node[j*IN_W +: IN_W] = in_data[j];
  end

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int unsigned CNT = N >> l;
    localparam int unsigned W   = IN_W + l;
    localparam int unsigned SRC = lvl_off(l - 1);
    localparam int unsigned DST = lvl_off(l);

    logic signed [W-1:0] sum_q [CNT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < CNT; j++) sum_q[j] <= '0;
      end else if (clear) begin
        for (int j = 0; j < CNT; j++) sum_q[j] <= '0;
      end else begin
        for (int j = 0; j < CNT; j++) begin
          sum_q[j] <= W'($signed(node[SRC + 2*j*(W-1) +: W-1]))
                    + W'($signed(node[SRC + (2*j+1)*(W-1) +: W-1]));
        end
      end
    end

    for (genvar j = 0; j < CNT; j++) begin : g_out
      assign node[DST + j*W +: W] = sum_q[j];
    end
  end

  assign sum = node[lvl_off(LVLS) +: OUT_W];

endmodule

// File: rtl/fir_pipelined.sv
// Fully pipelined direct-form FIR with double-buffered coefficients and saturating output.
// Define FIR_ROUND_EN to round half up before the output shift; default truncates.
module fir_pipelined
  import fir_pkg::*;
#(
  parameter int unsigned TAPS      = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned OUT_SHIFT = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coeff_wr_addr,
  input  logic signed [COEF_W-1:0]   coeff_wr_data,
  input  logic                       coeff_commit,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_sat
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_w(TAPS, DATA_W, COEF_W);
  localparam int unsigned LAT    = latency(TAPS);
`ifdef FIR_ROUND_EN
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) <<< (OUT_SHIFT - 1);
`else
  localparam int unsigned SUM_W  = ACC_W;
`endif
  localparam logic signed [DATA_W-1:0] MAX_D = DATA_W'(sat_max(DATA_W));
  localparam logic signed [DATA_W-1:0] MIN_D = DATA_W'(sat_min(DATA_W));

  logic signed [COEF_W-1:0] coef_shd_q [TAPS];
  logic signed [COEF_W-1:0] coef_act_q [TAPS];
  logic signed [DATA_W-1:0] d_q        [TAPS];
  logic signed [PROD_W-1:0] prod_q     [TAPS];
  logic        [LAT-1:0]    valid_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SUM_W-1:0]  acc_rnd;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [DATA_W-1:0] data_d, out_data_q;
  logic                     sat_d, out_sat_q;

  // Commit samples the shadow bank before this cycle's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_shd_q[i] <= '0;
        coef_act_q[i] <= '0;
      end
    end else begin
      if (coeff_commit) coef_act_q <= coef_shd_q;
      if (coeff_wr_en)  coef_shd_q[coeff_wr_addr] <= coeff_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        d_q[i]    <= '0;
        prod_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) begin
        d_q[i]    <= '0;
        prod_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      if (in_valid) begin
        d_q[0] <= in_data;
        for (int i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
      end
      for (int i = 0; i < TAPS; i++) prod_q[i] <= PROD_W'(d_q[i]) * PROD_W'(coef_act_q[i]);
      valid_q <= {valid_q[LAT-2:0], in_valid};
    end
  end

  fir_adder_tree #(
    .N    (TAPS),
    .IN_W (PROD_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .in_data (prod_q),
    .sum     (acc)
  );

`ifdef FIR_ROUND_EN
  assign acc_rnd = SUM_W'(acc) + HALF;
`else
  assign acc_rnd = acc;
`endif

  // Out of range whenever the bits above the output sign bit are not all sign copies.
  always_comb begin
    sum_s = acc_rnd >>> OUT_SHIFT;
    sat_d = !((&sum_s[SUM_W-1:DATA_W-1]) || !(|sum_s[SUM_W-1:DATA_W-1]));
    if (!sat_d)               data_d = sum_s[DATA_W-1:0];
    else if (sum_s[SUM_W-1])  data_d = MIN_D;
    else                      data_d = MAX_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (clear) begin
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      out_data_q <= data_d;
      out_sat_q  <= sat_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_pipelined.sv
// Scoreboard bench for fir_pipelined at default parameters (32 taps, Q14 output shift).
module tb_fir_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        coeff_wr_en = 1'b0;
  logic [4:0]  coeff_wr_addr = '0;
  logic [15:0] coeff_wr_data = '0;
  logic        coeff_commit = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   n_before;

`ifdef FIR_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  fir_pipelined u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .coeff_commit  (coeff_commit),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sat       (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got data %0d sat %0b, required no output",
                 $signed(out_data), out_sat);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.data || out_sat !== mon_e.sat) begin
          errors++;
          $display("FAIL out_sample: got data %0d sat %0b, required data %0d sat %0b",
                   $signed(out_data), out_sat, $signed(mon_e.data), mon_e.sat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] ed, input logic es);
    in_valid = 1'b1;
    in_data  = x;
    exp_q.push_back(exp_t'{data: ed, sat: es});
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_raw(input logic [15:0] x);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic load_coef(input int addr, input logic [15:0] val);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 5'(addr);
    coeff_wr_data = val;
    tick();
    coeff_wr_en   = 1'b0;
  endtask

  task automatic commit();
    coeff_commit = 1'b1;
    tick();
    coeff_commit = 1'b0;
  endtask

  task automatic clear_pipe();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    rst_n = 1'b1;
    tick();

    // Latency: one sample, coefficients still zero.
    in_valid = 1'b1;
    in_data  = 16'd100;
    exp_q.push_back(exp_t'{data: 16'd0, sat: 1'b0});
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      chk($sformatf("latency_c%0d", n), 32'(out_valid), 32'(n == 8));
    end
    drain();

    // Saturation both ways.
    for (int k = 0; k < 32; k++) load_coef(k, 16'h7fff);
    commit();
    clear_pipe();
    repeat (4) send(16'h7fff, 16'h7fff, 1'b1);
    drain();
    clear_pipe();
    repeat (4) send(16'h8000, 16'h8000, 1'b1);
    drain();

    // Impulse response with coef[k] = k+1.
    for (int k = 0; k < 32; k++) load_coef(k, 16'(k + 1));
    commit();
    clear_pipe();
    send(16'd16384, 16'd1, 1'b0);
    for (int j = 1; j < 34; j++) send(16'd0, (j < 32) ? 16'(j + 1) : 16'd0, 1'b0);
    drain();

    // Rewrite shadow as 32-k while streaming; active bank must not change.
    clear_pipe();
    for (int j = 0; j < 34; j++) begin
      coeff_wr_en   = (j < 32);
      coeff_wr_addr = 5'(j);
      coeff_wr_data = 16'(32 - j);
      send((j == 0) ? 16'd16384 : 16'd0, (j < 32) ? 16'(j + 1) : 16'd0, 1'b0);
    end
    coeff_wr_en = 1'b0;
    drain();

    // Same-cycle write + commit: commit takes the pre-write shadow value.
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 5'd0;
    coeff_wr_data = 16'd7;
    coeff_commit  = 1'b1;
    tick();
    coeff_wr_en   = 1'b0;
    coeff_commit  = 1'b0;
    clear_pipe();
    send(16'd16384, 16'd32, 1'b0);
    send(16'd0, 16'd31, 1'b0);
    drain();
    commit();
    clear_pipe();
    send(16'd16384, 16'd7, 1'b0);
    send(16'd0, 16'd31, 1'b0);
    drain();

    // Clear with samples in flight; the in_valid alongside clear is dropped too.
    clear_pipe();
    repeat (5) send_raw(16'd16384);
    n_before = n_out;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd16384;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (12) tick();
    chk("clear_no_valid", 32'(n_out - n_before), 32'd0);
    send(16'd16384, 16'd7, 1'b0);
    send(16'd0, 16'd31, 1'b0);
    send(16'd0, 16'd30, 1'b0);
    drain();

    // Asynchronous reset mid-stream.
    repeat (5) send_raw(16'd16384);
    n_before = n_out;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("rst_no_valid", 32'(n_out - n_before), 32'd0);
    load_coef(0, 16'd1);
    load_coef(5, 16'd1);
    commit();
    send(16'd16384, 16'd1, 1'b0);
    send(16'd0, 16'd0, 1'b0);
    send(16'd0, 16'd0, 1'b0);
    drain();

    // Rounding versus truncation toward -inf, only coef0 = 1.
    load_coef(5, 16'd0);
    commit();
    clear_pipe();
    send(16'd8192, {15'd0, RND}, 1'b0);
    send(16'he000, RND ? 16'h0000 : 16'hffff, 1'b0);
    drain();

    // Output range edges with coef0 = 1.0 in Q14, then just above it.
    load_coef(0, 16'd16384);
    commit();
    clear_pipe();
    send(16'h7fff, 16'h7fff, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    drain();
    load_coef(0, 16'd16385);
    commit();
    clear_pipe();
    send(16'h7fff, 16'h7fff, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_pipelined.md
# fir_pipelined

Parametrised, fully pipelined direct-form FIR filter for the streaming DSP datapath. It sits between the sample source and the sample sink, which are both valid-only and have no backpressure. Coefficients are loaded through a double-buffered register interface driven by the CSR block, so a new coefficient set takes effect atomically. The block generalises the 32-tap/16-bit filter to arbitrary power-of-two tap count and widths, and adds valid propagation, per-sample saturation flagging and synchronous clear.

## Interface
- TAPS, 32, number of taps; power of two, 2..128
- DATA_W, 16, signed sample width (input and output)
- COEF_W, 16, signed coefficient width
- OUT_SHIFT, 14, arithmetic right shift applied to accumulator before saturation; 1..ACC_W-DATA_W
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of delay line and pipeline
- coeff_wr_en  in  1  write shadow coefficient
- coeff_wr_addr  in  $clog2(TAPS)  shadow coefficient index
- coeff_wr_data  in  COEF_W  signed coefficient value
- coeff_commit  in  1  copy whole shadow bank to active bank
- in_valid  in  1  in_data is a new sample this cycle
- in_data  in  DATA_W  signed input sample
- out_valid  out  1  out_data/out_sat valid this cycle
- out_data  out  DATA_W  signed filtered sample
- out_sat  out  1  out_data was clipped

## Operation
- ACC_W = DATA_W + COEF_W + $clog2(TAPS); all arithmetic signed, full precision, no intermediate truncation.
- Delay line d[0..TAPS-1] shifts only on in_valid: d[0] <= in_data, d[i] <= d[i-1].
- Products p[i] = d[i] * active_coef[i] are registered every cycle, with full width DATA_W+COEF_W.
- Binary adder tree: $clog2(TAPS) registered levels, each level growing 1 bit; registered every cycle.
- Output stage: s = acc >>> OUT_SHIFT. If s > 2^(DATA_W-1)-1, then out_data = max and out_sat = 1. If s < -2^(DATA_W-1), then out_data = min and out_sat = 1. Otherwise out_data = s[DATA_W-1:0] and out_sat = 0.
- The valid shift register is L bits deep and carries in_valid alongside the data. out_valid is its last bit.
- Coefficients:
  - coeff_wr_en writes the shadow bank at coeff_wr_addr.
  - coeff_commit copies the shadow bank to the active bank in one cycle.
  - If a write and a commit occur in the same cycle, the commit copies the pre-write shadow contents and the write lands in shadow only.
- clear: zeroes the delay line, products, adder tree, output registers and valid pipe on the next edge. in_valid in the same cycle is ignored. Coefficient banks are untouched.
- Reset: both coefficient banks and all datapath registers go to 0. out_valid=0, out_data=0, out_sat=0. Asserting reset mid-stream discards all in-flight samples.

## Timing
- L = 3 + $clog2(TAPS) cycles: delay line (1), product (1), tree ($clog2(TAPS)), output (1). L = 8 for TAPS=32.
- A sample with in_valid at edge k produces out_valid=1 at edge k+L. One output per input, in order, with no gaps added.
- Full throughput: in_valid may be high every cycle.
- A commit at edge c applies to products registered at edge c+1 and later. Samples already in the tree keep their old coefficients, so the output mixes old and new coefficients for up to L-1 outputs.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FIR_ROUND_EN defined: adds 2^(OUT_SHIFT-1) to acc before the shift (round half up), with ACC_W+1 internal width.
- FIR_ROUND_EN undefined: plain truncation toward −∞ (arithmetic shift).

## Structure
- Shared package fir_pkg: acc_w(TAPS, DATA_W, COEF_W) function, latency function, and saturation limit helpers.
- Sub-module fir_adder_tree (parameters N, IN_W): registered pairwise reduction with log2(N) stages; instantiated once.

## Test plan
Defaults, truncation build unless noted.
- Impulse: active coef[k]=k+1, in_data=16384 once then zeros → 32 outputs equal 1,2,…,32, then 0; out_sat=0.
- Latency: single in_valid at cycle 0 with all pipes idle → out_valid high exactly at cycle 8 and for exactly one cycle.
- Saturation: all coefs 0x7FFF, in_data 0x7FFF continuous → out_data 0x7FFF, out_sat=1. Same with in_data 0x8000 → out_data 0x8000, out_sat=1.
- Commit atomicity: write new shadow values over 32 cycles while streaming → outputs unchanged until commit. Same-cycle write+commit → written value not active until the next commit.
- Clear/reset mid-stream: assert clear with 5 samples in flight → no out_valid for those samples, and the next impulse response starts from zeros. Repeat with rst_n → same result, with coefficients zeroed.
- Rounding (FIR_ROUND_EN): coef0=1, others 0, in_data=8192 → out_data=1. Without the macro → out_data=0.
